// File: rtl/proc_net_interface.sv
// Processor-side network interface for a 2x2 mesh node.
// TX path: core words are wrapped into flits and queued in a small FIFO
// whose head is presented to the router (first-word fall-through).
// RX path: a two-state FSM captures one flit addressed to this node and
// holds it until the core takes it; flits for other nodes are dropped
// with a one-cycle misroute pulse.
//
// state | meaning
// IDLE  | ready for a router flit, nothing held for the core
// HOLD  | one RX word held on wd_NI/rx_src until proc_ready_in
module proc_net_interface #(
  parameter logic [1:0]  LOCAL_ADDR = 2'b00,
  parameter int unsigned TX_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        proc_valid,
  input  logic        proc_ready_in,
  input  logic [1:0]  dest_add,
  input  logic [31:0] NI_in,
  output logic        mips_ni,
  output logic        data_valid,
  output logic [31:0] wd_NI,
  output logic [1:0]  rx_src,
  output logic [35:0] tx_flit,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [35:0] rx_flit,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        rx_misroute
);

  localparam int unsigned AW      = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TX_DEPTH);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} rx_state_t;

  logic [35:0]   mem [TX_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  rx_state_t     rx_state;

  // Status is gated by rst so the core and router see an idle interface
  // throughout reset; full-ness uses the pre-edge count, so a pop cannot
  // make room for a push on the same edge.
  assign mips_ni  = ~rst & (count < DEPTH_C);
  assign tx_valid = ~rst & (count != '0);
  assign tx_flit  = mem[rd_ptr];
  assign push     = proc_valid & mips_ni;
  assign pop      = tx_valid & tx_ready;

  // FIFO storage: write the wrapped flit at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {LOCAL_ADDR, dest_add, NI_in};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // RX FSM with registered handshake, hold and misroute outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= IDLE;
      rx_ready    <= 1'b0;
      data_valid  <= 1'b0;
      wd_NI       <= '0;
      rx_src      <= '0;
      rx_misroute <= 1'b0;
    end else begin
      rx_misroute <= 1'b0;
      case (rx_state)
        IDLE: begin
          rx_ready   <= 1'b1;
          data_valid <= 1'b0;
          if (rx_valid) begin
            if (rx_flit[33:32] == LOCAL_ADDR) begin
              wd_NI      <= rx_flit[31:0];
              rx_src     <= rx_flit[35:34];
              rx_ready   <= 1'b0;
              data_valid <= 1'b1;
              rx_state   <= HOLD;
            end else begin
              rx_misroute <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (proc_ready_in) begin
            rx_ready   <= 1'b1;
            data_valid <= 1'b0;
            rx_state   <= IDLE;
          end
        end
        default: begin
          rx_state   <= IDLE;
          rx_ready   <= 1'b1;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_net_interface.sv
// Self-checking bench for proc_net_interface: a queue models the TX FIFO,
// a held-word record models the RX side, and directed plus random stimulus
// is compared against it one cycle at a time.
module tb_proc_net_interface;

  localparam int         DEPTH = 4;
  localparam logic [1:0] LOC   = 2'b00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        proc_valid = 1'b0;
  logic        proc_ready_in = 1'b0;
  logic [1:0]  dest_add = '0;
  logic [31:0] NI_in = '0;
  logic        tx_ready = 1'b0;
  logic [35:0] rx_flit = '0;
  logic        rx_valid = 1'b0;
  logic        mips_ni, data_valid, tx_valid, rx_ready, rx_misroute;
  logic [31:0] wd_NI;
  logic [1:0]  rx_src;
  logic [35:0] tx_flit;

  proc_net_interface #(.LOCAL_ADDR(LOC), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .proc_valid(proc_valid), .proc_ready_in(proc_ready_in),
    .dest_add(dest_add), .NI_in(NI_in), .mips_ni(mips_ni), .data_valid(data_valid),
    .wd_NI(wd_NI), .rx_src(rx_src), .tx_flit(tx_flit), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_misroute(rx_misroute)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [35:0] q[$];
  logic [35:0] obs_log[$];
  bit          m_live = 0;
  bit          m_hold = 0;
  bit          m_mis = 0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_src = '0;
  bit          last_push = 0;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance the model, compare.
  task automatic tick();
    bit push, pop;
    push = proc_valid && !rst && (q.size() < DEPTH);
    pop  = !rst && (q.size() != 0) && tx_ready;
    if (!rst && q.size() != 0) check("tx_flit_head", tx_flit, q[0]);
    if (pop) obs_log.push_back(tx_flit);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_live = 0; m_hold = 0; m_mis = 0; m_data = '0; m_src = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({LOC, dest_add, NI_in});
      m_live = 1;
      m_mis  = 0;
      if (!m_hold) begin
        if (rx_valid) begin
          if (rx_flit[33:32] == LOC) begin
            m_hold = 1; m_data = rx_flit[31:0]; m_src = rx_flit[35:34];
          end else begin
            m_mis = 1;
          end
        end
      end else if (proc_ready_in) begin
        m_hold = 0;
      end
    end
    last_push = push;
    #1;
    check("mips_ni", 36'(mips_ni), 36'(!rst && q.size() < DEPTH));
    check("tx_valid", 36'(tx_valid), 36'(!rst && q.size() != 0));
    check("data_valid", 36'(data_valid), 36'(m_hold));
    check("rx_ready", 36'(rx_ready), 36'(m_live && !m_hold));
    check("wd_NI", 36'(wd_NI), 36'(m_data));
    check("rx_src", 36'(rx_src), 36'(m_src));
    check("rx_misroute", 36'(rx_misroute), 36'(m_mis));
  endtask

  initial begin
    logic [31:0] words[10];
    int idx;
    int cyc;

    // reset and first cycle out of reset
    rst = 1'b1;
    tick(); tick();
    check("rst_mips_ni", 36'(mips_ni), 36'(0));
    check("rst_rx_ready", 36'(rx_ready), 36'(0));
    rst = 1'b0;
    tick();
    check("post_rst_mips_ni", 36'(mips_ni), 36'(1));
    check("post_rst_rx_ready", 36'(rx_ready), 36'(1));

    // FIFO fill: A1..A4 fill, A5 dropped, drain in order
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      proc_valid = 1'b1; dest_add = 2'b01; NI_in = 32'hA000_0001 + i;
      tick();
    end
    check("fill_mips_ni", 36'(mips_ni), 36'(0));
    NI_in = 32'hA000_0005;
    tick();
    check("a5_refused", 36'(last_push), 36'(0));
    proc_valid = 1'b0;
    obs_log.delete();
    tx_ready = 1'b1;
    repeat (6) tick();
    check("fill_out_count", 36'(obs_log.size()), 36'(4));
    for (int i = 0; i < 4 && i < obs_log.size(); i++) begin
      check("fill_out_word", obs_log[i], {LOC, 2'b01, 32'hA000_0001 + i});
      check("fill_out_hdr", 36'(obs_log[i][35:32]), 36'(4'b0001));
    end

    // simultaneous push/pop at full and at count 2
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      proc_valid = 1'b1; dest_add = 2'(i); NI_in = 32'hB000_0000 + i;
      tick();
    end
    tx_ready = 1'b1; proc_valid = 1'b1; NI_in = 32'hB000_00FF;
    tick();
    check("full_pushpop_refused", 36'(last_push), 36'(0));
    check("full_pushpop_mips", 36'(mips_ni), 36'(1));
    proc_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      proc_valid = 1'b1; NI_in = 32'hC000_0000 + i;
      tick();
      check("cnt2_pushpop_accepted", 36'(last_push), 36'(1));
    end
    proc_valid = 1'b0;
    repeat (4) tick();
    check("drained_tx_valid", 36'(tx_valid), 36'(0));

    // RX hold
    rx_valid = 1'b1; rx_flit = {2'b10, 2'b00, 32'hDEADBEEF}; proc_ready_in = 1'b0;
    tick();
    rx_flit = {2'b01, 2'b00, 32'h0BAD_F00D};
    check("hold_dv", 36'(data_valid), 36'(1));
    check("hold_wd", 36'(wd_NI), 36'(32'hDEADBEEF));
    check("hold_src", 36'(rx_src), 36'(2'b10));
    check("hold_rdy", 36'(rx_ready), 36'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_stable_wd", 36'(wd_NI), 36'(32'hDEADBEEF));
    end
    rx_valid = 1'b0; proc_ready_in = 1'b1;
    tick();
    proc_ready_in = 1'b0;
    check("release_dv", 36'(data_valid), 36'(0));
    check("release_rdy", 36'(rx_ready), 36'(1));

    // misroute
    rx_valid = 1'b1; rx_flit = {2'b01, 2'b11, 32'h1234_5678};
    tick();
    rx_valid = 1'b0;
    check("mis_pulse", 36'(rx_misroute), 36'(1));
    check("mis_dv", 36'(data_valid), 36'(0));
    tick();
    check("mis_pulse_end", 36'(rx_misroute), 36'(0));
    check("mis_idle_rdy", 36'(rx_ready), 36'(1));

    // reset mid-operation
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      proc_valid = 1'b1; dest_add = 2'b10; NI_in = 32'hD000_0000 + i;
      tick();
    end
    proc_valid = 1'b0;
    rx_valid = 1'b1; rx_flit = {2'b11, 2'b00, 32'hCAFE_0001};
    tick();
    rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_tx_valid", 36'(tx_valid), 36'(0));
    check("mid_rst_dv", 36'(data_valid), 36'(0));
    check("mid_rst_wd", 36'(wd_NI), 36'(0));
    rst = 1'b0;
    tick();
    check("after_rst_mips", 36'(mips_ni), 36'(1));
    check("after_rst_rdy", 36'(rx_ready), 36'(1));
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_flit", 36'(tx_valid), 36'(0));
    end

    // pointer wrap: 10 words at full rate with random tx_ready
    for (int i = 0; i < 10; i++) words[i] = $urandom;
    obs_log.delete();
    idx = 0;
    cyc = 0;
    while ((idx < 10 || q.size() != 0) && cyc < 200) begin
      proc_valid = (idx < 10);
      NI_in = (idx < 10) ? words[idx] : 32'h0;
      dest_add = 2'($urandom_range(0, 3));
      tx_ready = 1'($urandom);
      tick();
      if (last_push) idx++;
      cyc++;
    end
    proc_valid = 1'b0;
    check("wrap_done_in_budget", 36'(cyc < 200), 36'(1));
    check("wrap_count", 36'(obs_log.size()), 36'(10));
    for (int i = 0; i < 10 && i < obs_log.size(); i++)
      check("wrap_order", 36'(obs_log[i][31:0]), 36'(words[i]));

    // random concurrent TX/RX activity
    for (int i = 0; i < 400; i++) begin
      proc_valid    = 1'($urandom);
      dest_add      = 2'($urandom_range(0, 3));
      NI_in         = $urandom;
      tx_ready      = 1'($urandom);
      rx_valid      = 1'($urandom);
      rx_flit       = {4'($urandom), $urandom};
      proc_ready_in = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
